// File: rtl/tsc_pkg.sv
// Shared types and constants for the trigger-sampling controller.
package tsc_pkg;

    localparam int DEPTH  = 32;
    localparam int PTR_W  = 5;
    localparam int DATA_W = 8;

    localparam int DEF_THRESHOLD = 200;
    localparam int DEF_POST_TRIG = 16;
    localparam int DEF_ADC_STEP  = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_POST_TRIG = 3'd2,
        ST_WAIT_SEND = 3'd3,
        ST_SENDING   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/tsc_adc_model.sv
// ADC model: one-cycle request, data valid the cycle after, sample k = ADC_STEP*k mod 256.
module tsc_adc_model
    import tsc_pkg::*;
#(
    parameter int ADC_STEP = DEF_ADC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_enable,
    output logic              o_request,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_request;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_index;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_request <= 1'b0;
            r_ready   <= 1'b0;
            r_data    <= '0;
            r_index   <= '0;
        end else begin
            // Alternating request/ready gives one sample every two cycles.
            r_request <= i_enable && !r_request;
            r_ready   <= r_request;
            if (r_request) begin
                r_data  <= r_index * DATA_W'(ADC_STEP);
                r_index <= r_index + DATA_W'(1);
            end
        end
    end

    assign o_request = r_request;
    assign o_ready   = r_ready;
    assign o_data    = r_data;

endmodule

// File: rtl/tsc.sv
// Trigger-sampling controller: ring-buffer capture around a threshold trigger,
// then a full oldest-first buffer dump when the sender is free.
module tsc
    import tsc_pkg::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int POST_TRIG = DEF_POST_TRIG,
    parameter int ADC_STEP  = DEF_ADC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        SBF,
    output logic [2:0]  state,
    output logic        adc_request_out,
    output logic        adc_ready_out,
    output logic [7:0]  adc_data_out,
    output logic [4:0]  read_ptr_out,
    output logic [4:0]  write_ptr_out,
    output logic [7:0]  ring_buffer_read_ptr,
    output logic [7:0]  ring_buffer_write_ptr,
    output logic [4:0]  remaining_values_out,
    output logic        TRD_out,
    output logic        SD_out,
    output logic        CD_out
);

    state_t            r_state;
    state_t            w_next_state;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_remaining;
    logic [PTR_W-1:0]  r_send_cnt;
    logic              r_trd;
    logic              r_sd;
    logic              r_cd;

    logic              w_adc_request;
    logic              w_adc_ready;
    logic [DATA_W-1:0] w_adc_data;
    logic              w_adc_en;
    logic              w_start_ok;
    logic              w_capturing;
    logic              w_write;
    logic              w_trigger;
    logic              w_post_last;
    logic              w_enter_wait;

    assign w_start_ok   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_capturing  = (r_state == ST_RUNNING) || (r_state == ST_POST_TRIG);
    assign w_write      = w_capturing && w_adc_ready;
    assign w_trigger    = (r_state == ST_RUNNING) && w_write && (w_adc_data >= DATA_W'(THRESHOLD));
    assign w_post_last  = (r_state == ST_POST_TRIG) && w_write && (r_remaining == PTR_W'(1));
    assign w_enter_wait = (r_state != ST_WAIT_SEND) && (w_next_state == ST_WAIT_SEND);
    // Withhold the request on the final capture edge so nothing is in flight in WAIT_SEND.
    assign w_adc_en     = w_capturing && !w_enter_wait;

    tsc_adc_model #(
        .ADC_STEP (ADC_STEP)
    ) u_adc (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_start_ok),
        .i_enable  (w_adc_en),
        .o_request (w_adc_request),
        .o_ready   (w_adc_ready),
        .o_data    (w_adc_data)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default at the top of the block means every path assigns
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next_state = ST_RUNNING;
            ST_RUNNING:       if (w_trigger)
                                  w_next_state = (POST_TRIG == 0) ? ST_WAIT_SEND : ST_POST_TRIG;
            ST_POST_TRIG:     if (w_post_last) w_next_state = ST_WAIT_SEND;
            ST_WAIT_SEND:     if (SBF) w_next_state = ST_SENDING;
            ST_SENDING:       if (r_send_cnt == PTR_W'(DEPTH - 1)) w_next_state = ST_DONE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: the buffer is a plain register array cleared on reset because the
    // read views must show zero after reset; it cannot map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_write) begin
            r_mem[r_wr_ptr] <= w_adc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_send_cnt  <= '0;
            r_trd       <= 1'b0;
            r_sd        <= 1'b0;
            r_cd        <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_remaining <= '0;
                r_send_cnt  <= '0;
                r_trd       <= 1'b0;
                r_sd        <= 1'b0;
                r_cd        <= 1'b0;
            end

            if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);

            if (w_trigger)
                r_remaining <= PTR_W'(POST_TRIG);
            else if ((r_state == ST_POST_TRIG) && w_write)
                r_remaining <= r_remaining - PTR_W'(1);

            // The entry just past the final write is the oldest sample in the ring.
            if (w_enter_wait) begin
                r_trd    <= 1'b1;
                r_rd_ptr <= r_wr_ptr + PTR_W'(1);
            end

            if ((r_state == ST_WAIT_SEND) && SBF) begin
                r_trd      <= 1'b0;
                r_sd       <= 1'b1;
                r_send_cnt <= '0;
            end

            if (r_state == ST_SENDING) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (r_send_cnt == PTR_W'(DEPTH - 1)) begin
                    r_sd <= 1'b0;
                    r_cd <= 1'b1;
                end else begin
                    r_send_cnt <= r_send_cnt + PTR_W'(1);
                end
            end
        end
    end

    assign state                 = r_state;
    assign adc_request_out       = w_adc_request;
    assign adc_ready_out         = w_adc_ready;
    assign adc_data_out          = w_adc_data;
    assign read_ptr_out          = r_rd_ptr;
    assign write_ptr_out         = r_wr_ptr;
    assign ring_buffer_read_ptr  = r_mem[r_rd_ptr];
    assign ring_buffer_write_ptr = r_mem[r_wr_ptr];
    assign remaining_values_out  = r_remaining;
    assign TRD_out               = r_trd;
    assign SD_out                = r_sd;
    assign CD_out                = r_cd;

endmodule

// File: tb/tb_tsc.sv
// Scoreboard bench for tsc: expected samples/bytes are queued when stimulus is
// driven and popped as the DUT presents them.
module tb_tsc;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       SBF;
    logic [2:0] state;
    logic       adc_request_out;
    logic       adc_ready_out;
    logic [7:0] adc_data_out;
    logic [4:0] read_ptr_out;
    logic [4:0] write_ptr_out;
    logic [7:0] ring_buffer_read_ptr;
    logic [7:0] ring_buffer_write_ptr;
    logic [4:0] remaining_values_out;
    logic       TRD_out;
    logic       SD_out;
    logic       CD_out;

    typedef struct {
        int addr;
        int value;
    } sample_t;

    sample_t sample_q[$];
    int      byte_q[$];
    int      mdl_mem[32];
    int      n_cmp = 0;
    int      n_bad = 0;

    tsc dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .SBF                   (SBF),
        .state                 (state),
        .adc_request_out       (adc_request_out),
        .adc_ready_out         (adc_ready_out),
        .adc_data_out          (adc_data_out),
        .read_ptr_out          (read_ptr_out),
        .write_ptr_out         (write_ptr_out),
        .ring_buffer_read_ptr  (ring_buffer_read_ptr),
        .ring_buffer_write_ptr (ring_buffer_write_ptr),
        .remaining_values_out  (remaining_values_out),
        .TRD_out               (TRD_out),
        .SD_out                (SD_out),
        .CD_out                (CD_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"},    state, 0);
        check({tag, " req"},      adc_request_out, 0);
        check({tag, " rdy"},      adc_ready_out, 0);
        check({tag, " data"},     adc_data_out, 0);
        check({tag, " rd_ptr"},   read_ptr_out, 0);
        check({tag, " wr_ptr"},   write_ptr_out, 0);
        check({tag, " rb_rd"},    ring_buffer_read_ptr, 0);
        check({tag, " rb_wr"},    ring_buffer_write_ptr, 0);
        check({tag, " remain"},   remaining_values_out, 0);
        check({tag, " TRD"},      TRD_out, 0);
        check({tag, " SD"},       SD_out, 0);
        check({tag, " CD"},       CD_out, 0);
    endtask

    // Start a capture and follow it to TRD_out, with SBF toggling to prove it is ignored.
    task automatic run_capture(input string tag);
        int      t;
        int      k;
        int      last_t;
        bit      got_trd;
        sample_t s;
        sample_q.delete();
        for (int j = 0; j < 46; j++) sample_q.push_back('{j % 32, (j * 7) % 256});

        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " start state"}, state, 1);
        check({tag, " start CD"}, CD_out, 0);
        check({tag, " start SD"}, SD_out, 0);

        t = 0; k = 0; last_t = 0; got_trd = 1'b0;
        while (t < 400) begin
            tick();
            t++;
            if (TRD_out) begin
                got_trd = 1'b1;
                break;
            end
            if (adc_ready_out) begin
                check({tag, " sample available"}, sample_q.size() > 0, 1);
                if (sample_q.size() > 0) begin
                    s = sample_q.pop_front();
                    check({tag, " sample value"}, adc_data_out, s.value);
                    check({tag, " sample addr"}, write_ptr_out, s.addr);
                    check({tag, " sample state"}, state, (k <= 29) ? 1 : 2);
                    if (k >= 30) check({tag, " remaining"}, remaining_values_out, 16 - (k - 30));
                    check({tag, " sample timing"}, t - last_t, 2);
                end
                k++;
                last_t = t;
            end
            SBF = (t % 5 == 0);
        end
        SBF = 1'b0;

        check({tag, " TRD reached"}, got_trd, 1);
        check({tag, " TRD latency"}, t, 93);
        check({tag, " wait state"}, state, 3);
        check({tag, " wait rd_ptr"}, read_ptr_out, 14);
        check({tag, " wait wr_ptr"}, write_ptr_out, 14);
        check({tag, " wait remain"}, remaining_values_out, 0);
        check({tag, " samples left"}, sample_q.size(), 0);
    endtask

    // Wait, pulse SBF and drain the buffer; stop_after < 32 abandons the send early.
    task automatic run_send(input string tag, input int stop_after);
        int n;
        byte_q.delete();
        for (int a = 0; a < 32; a++) byte_q.push_back(mdl_mem[(14 + a) % 32]);

        repeat (4) begin
            tick();
            check({tag, " hold state"}, state, 3);
            check({tag, " hold TRD"}, TRD_out, 1);
            check({tag, " hold req"}, adc_request_out, 0);
            check({tag, " hold rdy"}, adc_ready_out, 0);
        end

        SBF = 1'b1;
        tick();
        check({tag, " send SD"}, SD_out, 1);
        check({tag, " send TRD"}, TRD_out, 0);
        check({tag, " send state"}, state, 4);

        n = 0;
        while (SD_out && n < 64) begin
            if (n == stop_after) begin
                SBF = 1'b0;
                return;
            end
            check({tag, " byte available"}, byte_q.size() > 0, 1);
            if (byte_q.size() > 0) check({tag, " byte"}, ring_buffer_read_ptr, byte_q.pop_front());
            n++;
            if (n == 3) SBF = 1'b0;
            tick();
        end
        SBF = 1'b0;

        check({tag, " byte count"}, n, 32);
        check({tag, " done SD"}, SD_out, 0);
        check({tag, " done CD"}, CD_out, 1);
        check({tag, " done state"}, state, 5);
        check({tag, " bytes left"}, byte_q.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < 46; k++) mdl_mem[k % 32] = (k * 7) % 256;

        reset = 1'b1;
        start = 1'b0;
        SBF   = 1'b0;
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        check("idle hold", state, 0);

        run_capture("run1");
        run_send("run1", 99);
        repeat (3) begin
            tick();
            check("done hold", state, 5);
        end

        run_capture("run2");
        run_send("run2", 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midsend reset");

        run_capture("run3");
        run_send("run3", 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
